dds_phase_gen: RTL and testbench
================================

# dds_phase_gen

Phase-accumulator front end of the DDS sine generator. Accumulates a frequency control word (FCW) every enabled cycle and drives the address port of `sin_rom` with the top bits of the phase. Emits a valid flag aligned to the ROM's one-cycle read latency. FCW updates arrive over a valid/ready handshake and are applied phase-continuously, at the next phase wrap.

## Interface
- `PHASE_WIDTH`, 32, accumulator width in bits.
- `ROM_DEPTH`, 256, depth of the downstream sine ROM.
  - `ADDR_WIDTH = $clog2(ROM_DEPTH)`.
  - Requires `ADDR_WIDTH <= PHASE_WIDTH`.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  accumulate enable.
- `clr`  in  1  synchronous phase clear.
- `fcw_valid`  in  1  FCW offer.
- `fcw_data`  in  PHASE_WIDTH  new FCW.
- `fcw_ready`  out  1  FCW accept.
- `ROM_addr`  out  ADDR_WIDTH  phase address to `sin_rom`.
- `addr_valid`  out  1  `ROM_addr` holds a freshly advanced phase.
- `data_valid`  out  1  `sin_rom` output is valid this cycle.
- `wrap`  out  1  one-cycle pulse after phase overflow.

## Operation
- Registers:
  - `acc[PHASE_WIDTH]`.
  - `fcw_cur`, `fcw_pend`.
  - `state`: IDLE, RUN or PEND.
  - `addr_valid`, `data_valid`, `wrap`.
- Handshake:
  - `fcw_ready = (state != PEND)`.
  - A transfer occurs on any cycle with `fcw_valid && fcw_ready`.
- Accumulation:
  - If `en=1` and `clr=0`: `{carry, acc} <= acc + fcw_cur`, using `fcw_cur` as it was before this cycle's update.
  - The sum wraps modulo 2^PHASE_WIDTH. `carry` is the wrap event.
- `clr=1`:
  - `acc <= 0`. No carry is generated.
  - Counts as a wrap event for applying a pending FCW.
  - Leaves `fcw_cur` unchanged except via pending apply.
- State transitions:
  - IDLE:
    - A transfer loads `fcw_cur` directly.
    - `en=1` → RUN.
  - RUN:
    - A transfer with `en=1` stores `fcw_pend` → PEND.
    - A transfer with `en=0` loads `fcw_cur` → IDLE.
    - `en=0` → IDLE.
  - PEND:
    - Carry or `clr` → `fcw_cur <= fcw_pend`, then RUN (or IDLE if `en=0`).
    - `en=0` without wrap → `fcw_cur <= fcw_pend`, IDLE (pending applied immediately on stop).
- Outputs:
  - `ROM_addr = acc[PHASE_WIDTH-1 -: ADDR_WIDTH]`, driven directly from the register.
  - `addr_valid <= en & ~clr`.
  - `data_valid <= addr_valid`.
  - `wrap <= carry` (only when `en=1` and `clr=0`).
- FCW = 0 with `en=1`:
  - `acc` holds.
  - `addr_valid` stays high.
  - No wrap occurs, so a pending FCW waits until `clr` or `en` falls.

## Timing
- Reset values:
  - `acc=0`, `fcw_cur=0`, `fcw_pend=0`, state IDLE.
  - `ROM_addr=0`, `addr_valid=0`, `data_valid=0`, `wrap=0`, `fcw_ready=1`.
- `rst` has priority over `clr`, `en` and any handshake. Reset mid-PEND discards `fcw_pend`.
- Latency:
  - `en` rising at edge N → `acc` and `addr_valid` updated at N+1.
  - `ROM_data` valid at N+2, flagged by `data_valid` at N+2.
- `wrap` is asserted on the same cycle that `ROM_addr` shows the post-overflow phase.
- A transfer in RUN on the same cycle as a carry is stored as pending. It applies at the following wrap, not the current one.
- `fcw_ready` drops the cycle after a RUN-state transfer. It rises the cycle after the pending value is applied.
- No combinational path from `fcw_valid` to `fcw_ready`.

## Structure
- Shared package `dds_pkg`:
  - State enumeration: IDLE=2'd0, RUN=2'd1, PEND=2'd2.
  - Default `PHASE_WIDTH`/`ROM_DEPTH` constants, shared with the DDS top and `sin_rom` instantiation.
- Single flat module, no sub-module. The carry/accumulate adder is inline.
- Pairing with `sin_rom` is done in the DDS top, not here.

## Test plan
- Reset and idle:
  - Stimulus: reset, then `en=0` for 10 cycles.
  - Required: `ROM_addr=0`, `addr_valid=0`, `data_valid=0`, `wrap=0`, `fcw_ready=1` throughout.
- Basic sweep (defaults):
  - Stimulus: load FCW 0x0100_0000 in IDLE, then `en=1`.
  - Required: `ROM_addr` 1,2,…,255,0.
  - Required: `wrap` pulses once per 256 cycles, on the cycle `ROM_addr` returns to 0.
  - Required: `data_valid` lags `addr_valid` by exactly 1.
- Phase-continuous update:
  - Stimulus: running at FCW 0x0100_0000, offer 0x0400_0000 at `ROM_addr=10`.
  - Required: `fcw_ready` low until wrap.
  - Required: step stays 1 until `ROM_addr=0`; the next address is 4, then 8.
- Offer on carry cycle:
  - Stimulus: offer a new FCW on the cycle the carry occurs.
  - Required: held pending through one full cycle of the old FCW.
- Clear and stop:
  - Stimulus A: `clr` pulse while PEND.
  - Required A: `ROM_addr=0` next cycle, pending FCW applied, `wrap` stays 0, `addr_valid` low for that cycle.
  - Stimulus B: `en` dropped while PEND.
  - Required B: state IDLE, `fcw_cur` equals the pending value.
- Reset mid-operation:
  - Stimulus: assert `rst` during PEND with `ROM_addr=0x80`.
  - Required: all outputs at reset values next cycle; after restart the old pending FCW is not applied.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS definitions: default geometry and the phase-generator state encoding.
package dds_pkg;

  // Default geometry shared by the DDS top, the phase generator and sin_rom.
  localparam int PHASE_WIDTH_DEF = 32;
  localparam int ROM_DEPTH_DEF   = 256;

  // FCW update state: IDLE (stopped), RUN (accumulating), PEND (new FCW waiting for a wrap).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } phase_state_t;

endpackage

// File: rtl/dds_phase_gen.sv
// DDS phase accumulator. Adds the current FCW every enabled cycle and presents
// the top phase bits as the sin_rom address. FCW updates received while running
// are parked and applied at the next phase wrap (carry or clr), so the output
// phase never jumps mid-period. ROM_DEPTH must be a power of two whose log2 does
// not exceed PHASE_WIDTH.
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
  parameter int ROM_DEPTH   = ROM_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         fcw_valid,
  input  logic [PHASE_WIDTH-1:0]       fcw_data,
  output logic                         fcw_ready,
  output logic [$clog2(ROM_DEPTH)-1:0] ROM_addr,
  output logic                         addr_valid,
  output logic                         data_valid,
  output logic                         wrap
);

  localparam int ADDR_WIDTH = $clog2(ROM_DEPTH);

  logic [PHASE_WIDTH-1:0] acc_reg;
  logic [PHASE_WIDTH-1:0] fcw_cur_reg;
  logic [PHASE_WIDTH-1:0] fcw_pend_reg;
  phase_state_t           state_reg;

  logic [PHASE_WIDTH:0]   sum;
  logic                   advance;
  logic                   carry;
  logic                   xfer;

  // Inline accumulate adder; the extra top bit is the overflow (wrap) event.
  assign sum     = {1'b0, acc_reg} + {1'b0, fcw_cur_reg};
  assign advance = en & ~clr;
  assign carry   = advance & sum[PHASE_WIDTH];

  // Ready depends only on registered state, never on fcw_valid.
  assign fcw_ready = (state_reg != PEND);
  assign xfer      = fcw_valid & fcw_ready;

  assign ROM_addr = acc_reg[PHASE_WIDTH-1 -: ADDR_WIDTH];

  // Phase accumulation, output flags and FCW update FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg      <= '0;
      fcw_cur_reg  <= '0;
      fcw_pend_reg <= '0;
      state_reg    <= IDLE;
      addr_valid   <= 1'b0;
      data_valid   <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      addr_valid <= advance;
      data_valid <= addr_valid;  // sin_rom has one cycle of read latency
      wrap       <= carry;

      if (clr) begin
        acc_reg <= '0;
      end else if (en) begin
        acc_reg <= sum[PHASE_WIDTH-1:0];
      end

      case (state_reg)
        IDLE: begin
          if (xfer) begin
            fcw_cur_reg <= fcw_data;
          end
          if (en) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (xfer && en) begin
            // Even if a carry happens this same cycle, the new FCW waits for the next wrap.
            fcw_pend_reg <= fcw_data;
            state_reg    <= PEND;
          end else if (xfer) begin
            fcw_cur_reg <= fcw_data;
            state_reg   <= IDLE;
          end else if (!en) begin
            state_reg <= IDLE;
          end
        end
        PEND: begin
          // Apply on wrap, clear, or stop; a zero FCW never wraps, so stop/clr is the escape.
          if (carry || clr || !en) begin
            fcw_cur_reg <= fcw_pend_reg;
            state_reg   <= en ? RUN : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Randomized and directed bench for dds_phase_gen against an arithmetic reference model.
module tb_dds_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        fcw_valid = 1'b0;
  logic [31:0] fcw_data = '0;
  logic        fcw_ready;
  logic [7:0]  ROM_addr;
  logic        addr_valid;
  logic        data_valid;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: phase as plain integer arithmetic, pending FCWs as a queue,
  // and "running" meaning en was high on the previous cycle.
  longint unsigned m_phase = 0;
  longint unsigned m_cur = 0;
  logic [31:0]     m_pend[$];
  bit              m_prev_en = 0;
  bit              m_av = 0;
  bit              m_dv = 0;
  bit              m_wrap = 0;

  dds_phase_gen #(.PHASE_WIDTH(32), .ROM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .fcw_valid(fcw_valid), .fcw_data(fcw_data), .fcw_ready(fcw_ready),
    .ROM_addr(ROM_addr), .addr_valid(addr_valid), .data_valid(data_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit c, input bit v, input logic [31:0] d);
    longint unsigned s;
    bit adv, cy, xfer;
    if (r) begin
      m_phase = 0; m_cur = 0; m_pend.delete(); m_prev_en = 0;
      m_av = 0; m_dv = 0; m_wrap = 0;
    end else begin
      xfer = v && (m_pend.size() == 0);
      adv  = e && !c;
      s    = m_phase + m_cur;
      cy   = adv && (s >= 64'h1_0000_0000);
      if (m_pend.size() != 0) begin
        if (cy || c || !e) m_cur = m_pend.pop_front();
      end else if (xfer) begin
        if (m_prev_en && e) m_pend.push_back(d);
        else m_cur = d;
        $display("xfer fcw=0x%08h %s at phase 0x%08h", d, (m_prev_en && e) ? "pending" : "direct", m_phase[31:0]);
      end
      if (c) m_phase = 0;
      else if (e) m_phase = s & 64'hFFFF_FFFF;
      m_dv = m_av;
      m_av = adv;
      m_wrap = cy;
      m_prev_en = e;
    end
  endtask

  // One clock: apply inputs, advance model on the edge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit e, input bit c, input bit v, input logic [31:0] d);
    rst = r; en = e; clr = c; fcw_valid = v; fcw_data = d;
    @(posedge clk);
    model_step(r, e, c, v, d);
    #1;
    check("rom_addr",   64'(ROM_addr),   64'(m_phase >> 24));
    check("addr_valid", 64'(addr_valid), 64'(m_av));
    check("data_valid", 64'(data_valid), 64'(m_dv));
    check("wrap",       64'(wrap),       64'(m_wrap));
    check("fcw_ready",  64'(fcw_ready),  64'(m_pend.size() == 0));
  endtask

  task automatic run_until_addr(input logic [7:0] a);
    for (int i = 0; i < 300; i++) begin
      if ((m_phase >> 24) == 64'(a)) break;
      cyc(0, 1, 0, 0, '0);
    end
    check("reach_addr", 64'(ROM_addr), 64'(a));
  endtask

  initial begin
    // Reset and idle
    cyc(1, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    repeat (10) cyc(0, 0, 0, 0, '0);

    // Basic sweep, then phase-continuous update offered at address 10
    cyc(0, 0, 0, 1, 32'h0100_0000);
    repeat (256) cyc(0, 1, 0, 0, '0);
    run_until_addr(8'd10);
    cyc(0, 1, 0, 1, 32'h0400_0000);
    repeat (260) cyc(0, 1, 0, 0, '0);

    // Offer on the carry cycle: must wait a whole period of the old FCW
    for (int i = 0; i < 100; i++) begin
      if (m_phase + m_cur >= 64'h1_0000_0000) begin
        cyc(0, 1, 0, 1, 32'h1000_0000);
        break;
      end
      cyc(0, 1, 0, 0, '0);
    end
    repeat (140) cyc(0, 1, 0, 0, '0);

    // clr while pending
    cyc(0, 1, 0, 1, 32'h0200_0000);
    repeat (5) cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, '0);
    repeat (5) cyc(0, 1, 0, 0, '0);

    // en dropped while pending, then restart with the applied FCW
    cyc(0, 1, 0, 1, 32'h0300_0000);
    repeat (3) cyc(0, 1, 0, 0, '0);
    repeat (3) cyc(0, 0, 0, 0, '0);
    repeat (10) cyc(0, 1, 0, 0, '0);

    // Reset mid-pending at address 0x80; old pending FCW must be lost
    cyc(0, 0, 1, 1, 32'h0100_0000);
    run_until_addr(8'h70);
    cyc(0, 1, 0, 1, 32'h0800_0000);
    run_until_addr(8'h80);
    cyc(1, 1, 0, 0, '0);
    repeat (20) cyc(0, 1, 0, 0, '0);

    // FCW = 0 while running: phase holds, pending waits for clr
    cyc(0, 1, 0, 1, 32'h0500_0000);
    repeat (6) cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 1, 0, '0);
    repeat (6) cyc(0, 1, 0, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] d;
      d = $urandom() >> $urandom_range(0, 8);
      if ($urandom_range(0, 15) == 0) d = '0;
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
